// File: rtl/uart_rx_fifo_if.sv
//------------------------------------------------------------------------------
// uart_rx_fifo_if
//
// Purpose:
//   Bundles the signals between the UART receiver / host logic and the
//   uart_rx_fifo receive buffer. The signal names match the names used by the
//   surrounding UART receiver design.
//
// Parameters:
//   ADDR_W        log2 of the FIFO depth; sets the width of count.
//
// Signals:
//   P_DATA        [7:0]       received byte from the UART receiver
//   Data_valid                one-cycle strobe qualifying P_DATA and the flags
//   Parity_Error              receiver parity error level
//   Stop_Error                receiver stop-bit error level
//   rd_en                     host pop request
//   ovf_clr                   clears the sticky overflow flag
//   err_clr                   clears the frame-error counter
//   rd_data       [7:0]       head entry byte (zero while empty)
//   rd_err        [1:0]       head entry flags {parity_err, stop_err}
//   empty                     FIFO holds no entries
//   full                      FIFO holds DEPTH entries
//   count         [ADDR_W:0]  current occupancy, 0..DEPTH
//   overflow                  sticky: a write was lost
//   err_cnt       [7:0]       saturating count of frame-error events
//
// Modports:
//   master        receiver / host side (drives the requests)
//   slave         the FIFO itself (drives the status and read data)
//------------------------------------------------------------------------------
interface uart_rx_fifo_if #(
    parameter int ADDR_W = 3
) ();

    logic [7:0]      P_DATA;
    logic            Data_valid;
    logic            Parity_Error;
    logic            Stop_Error;
    logic            rd_en;
    logic            ovf_clr;
    logic            err_clr;

    logic [7:0]      rd_data;
    logic [1:0]      rd_err;
    logic            empty;
    logic            full;
    logic [ADDR_W:0] count;
    logic            overflow;
    logic [7:0]      err_cnt;

    modport master (
        output P_DATA, Data_valid, Parity_Error, Stop_Error,
        output rd_en, ovf_clr, err_clr,
        input  rd_data, rd_err, empty, full, count, overflow, err_cnt
    );

    modport slave (
        input  P_DATA, Data_valid, Parity_Error, Stop_Error,
        input  rd_en, ovf_clr, err_clr,
        output rd_data, rd_err, empty, full, count, overflow, err_cnt
    );

endinterface

// File: rtl/uart_rx_fifo.sv
//------------------------------------------------------------------------------
// uart_rx_fifo
//
// Purpose:
//   Receive-side byte buffer sitting directly after the UART receiver. Every
//   Data_valid strobe pushes {Parity_Error, Stop_Error, P_DATA} into a
//   first-word-fall-through FIFO that the host pops at its own pace on the
//   same clock. A sticky overflow flag records lost writes and a saturating
//   counter tallies rising edges of the receiver's error level.
//
// Parameters:
//   DEPTH         number of entries; power of two, at least 2
//   ADDR_W        log2(DEPTH)
//
// Ports:
//   CLK           system clock, rising edge
//   RST           synchronous, active-low reset
//   bus           uart_rx_fifo_if.slave:
//                   in : P_DATA, Data_valid, Parity_Error, Stop_Error,
//                        rd_en, ovf_clr, err_clr
//                   out: rd_data, rd_err, empty, full, count, overflow, err_cnt
//
// Build option:
//   UART_RX_FIFO_DROP_ERR_EN  when defined, a byte that arrives with either
//                             error flag set is discarded instead of stored
//                             (it is still counted by err_cnt and never sets
//                             overflow); rd_err then always reads 2'b00.
//------------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic           CLK,
    input  logic           RST,
    uart_rx_fifo_if.slave  bus
);

    localparam int ENTRY_W = 10;

    //--------------------------------------------------------------------------
    // State
    //--------------------------------------------------------------------------
    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]    r_wr_ptr;
    logic [ADDR_W:0]    r_rd_ptr;
    logic               r_overflow;
    logic [7:0]         r_err_cnt;
    logic               r_err_lvl_q;

    //--------------------------------------------------------------------------
    // Pointer-derived status
    //--------------------------------------------------------------------------
    logic               w_full;
    logic               w_empty;
    logic [ADDR_W:0]    w_count;

    // The extra pointer MSB tells a full FIFO (one lap ahead) from an empty one.
    assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    // Modulo-2*DEPTH difference is exactly the occupancy 0..DEPTH.
    assign w_count = r_wr_ptr - r_rd_ptr;

    //--------------------------------------------------------------------------
    // Write / read qualification
    //--------------------------------------------------------------------------
    logic               w_err_lvl;
    logic               w_wr_req;
    logic               w_wr_fire;
    logic               w_rd_fire;
    logic               w_ovf_evt;
    logic [ENTRY_W-1:0] w_wr_entry;

    assign w_err_lvl = bus.Parity_Error | bus.Stop_Error;

`ifdef UART_RX_FIFO_DROP_ERR_EN
    // Errored bytes never become a write request, so they can neither occupy a
    // slot nor be reported as lost.
    assign w_wr_req = bus.Data_valid & ~w_err_lvl;
`else
    assign w_wr_req = bus.Data_valid;
`endif

    assign w_wr_entry = {bus.Parity_Error, bus.Stop_Error, bus.P_DATA};

    // A pop on an empty FIFO is simply ignored.
    assign w_rd_fire = bus.rd_en & ~w_empty;
    // When full, a same-cycle pop frees the head slot, so the write still lands.
    // Full implies non-empty, so rd_en alone is a valid pop here.
    assign w_wr_fire = w_wr_req & (~w_full | bus.rd_en);
    assign w_ovf_evt = w_wr_req & w_full & ~bus.rd_en;

    //--------------------------------------------------------------------------
    // Storage
    //--------------------------------------------------------------------------
    // NOTE: the storage array has no reset; only the pointers define which
    // entries are live, so resetting the array would add nothing but logic.
    always_ff @(posedge CLK) begin
        if (RST && w_wr_fire) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= w_wr_entry;
        end
    end

    //--------------------------------------------------------------------------
    // Pointers
    //--------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Sticky overflow: a new lost write outranks a same-cycle clear.
    //--------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_evt) begin
            r_overflow <= 1'b1;
        end else if (bus.ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    //--------------------------------------------------------------------------
    // Frame-error counter
    //--------------------------------------------------------------------------
    // Counts rising edges of the combined error level, independent of
    // Data_valid, so a level held across several cycles counts once.
    logic w_err_rise;

    assign w_err_rise = w_err_lvl & ~r_err_lvl_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_err_lvl_q <= 1'b0;
        end else begin
            r_err_lvl_q <= w_err_lvl;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_err_cnt <= 8'h00;
        end else if (bus.err_clr) begin
            // A clear that coincides with a new edge leaves that edge counted.
            r_err_cnt <= w_err_rise ? 8'h01 : 8'h00;
        end else if (w_err_rise && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'h01;
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    logic [ENTRY_W-1:0] w_head;

    // Fall-through head, blanked while empty so stale storage never leaks out.
    assign w_head = w_empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];

    assign bus.rd_data  = w_head[7:0];
`ifdef UART_RX_FIFO_DROP_ERR_EN
    assign bus.rd_err   = 2'b00;
`else
    assign bus.rd_err   = w_head[9:8];
`endif
    assign bus.empty    = w_empty;
    assign bus.full     = w_full;
    assign bus.count    = w_count;
    assign bus.overflow = r_overflow;
    assign bus.err_cnt  = r_err_cnt;

endmodule
